// File: rtl/fa4_dual_adder_if.sv
// Operand/result bundle for fa4_dual_adder; err_cnt exists only when FA_SELFCHECK_EN is defined.
interface fa4_dual_adder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic [WIDTH-1:0] s1;
  logic             co1;
  logic [WIDTH-1:0] s2;
  logic             co2;
  logic             mismatch;
`ifdef FA_SELFCHECK_EN
  logic [7:0]       err_cnt;
`endif

  modport master (
    output in_valid, a, b, ci,
    input  out_valid, s1, co1, s2, co2, mismatch
`ifdef FA_SELFCHECK_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  in_valid, a, b, ci,
    output out_valid, s1, co1, s2, co2, mismatch
`ifdef FA_SELFCHECK_EN
    , output err_cnt
`endif
  );
endinterface

// File: rtl/fa4_dual_adder.sv
// Registered adder computing the sum twice (ripple of full-adder cells and a single wide add).
// FA_SELFCHECK_EN builds the cross-path comparison and a saturating error counter.
module fa4_dual_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  fa4_dual_adder_if.slave bus
);
  localparam int unsigned SW = WIDTH + 1;

  logic [WIDTH-1:0] rip_s;
  logic             rip_co;
  logic             rip_carry;
  logic [SW-1:0]    add_sum;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic             co1_q, co1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic             co2_q, co2_d;

  // Path 1: chain of full-adder cells, carry rippling from bit 0 upward
  always_comb begin
    rip_s     = '0;
    rip_carry = bus.ci;
    for (int i = 0; i < int'(WIDTH); i++) begin
      rip_s[i]  = bus.a[i] ^ bus.b[i] ^ rip_carry;
      rip_carry = (bus.a[i] & bus.b[i]) | (bus.a[i] & rip_carry) | (bus.b[i] & rip_carry);
    end
    rip_co = rip_carry;
  end

  // Path 2: one addition at WIDTH+1 bits so the carry is kept
  assign add_sum = SW'(bus.a) + SW'(bus.b) + SW'(bus.ci);

  always_comb begin
    out_valid_d = bus.in_valid;
    s1_d        = s1_q;
    co1_d       = co1_q;
    s2_d        = s2_q;
    co2_d       = co2_q;
    if (bus.in_valid) begin
      s1_d  = rip_s;
      co1_d = rip_co;
      s2_d  = add_sum[WIDTH-1:0];
      co2_d = add_sum[WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      s1_q        <= '0;
      co1_q       <= 1'b0;
      s2_q        <= '0;
      co2_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      s1_q        <= s1_d;
      co1_q       <= co1_d;
      s2_q        <= s2_d;
      co2_q       <= co2_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.s1        = s1_q;
  assign bus.co1       = co1_q;
  assign bus.s2        = s2_q;
  assign bus.co2       = co2_q;

`ifdef FA_SELFCHECK_EN
  logic       mismatch_q, mismatch_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Compare the values about to be captured; counter lags the registered flag by a cycle
  always_comb begin
    mismatch_d = bus.in_valid & ({co1_d, s1_d} != {co2_d, s2_d});
    err_cnt_d  = err_cnt_q;
    if (mismatch_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.mismatch = mismatch_q;
  assign bus.err_cnt  = err_cnt_q;
`else
  assign bus.mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_fa4_dual_adder.sv
// Directed bench for fa4_dual_adder (WIDTH=4); extra self-check section when FA_SELFCHECK_EN is defined.
module tb_fa4_dual_adder;
  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  fa4_dual_adder_if #(.WIDTH(WIDTH)) bus ();

  fa4_dual_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one input set at the falling edge, return 1ns after the next rising edge
  task automatic apply(input logic v, input logic [3:0] a, input logic [3:0] b, input logic ci);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.ci       = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ov, input logic [4:0] sum1,
                           input logic [4:0] sum2, input logic mm);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    check({tag, ".r1"}, 32'({bus.co1, bus.s1}), 32'(sum1));
    check({tag, ".r2"}, 32'({bus.co2, bus.s2}), 32'(sum2));
    check({tag, ".mismatch"}, 32'(bus.mismatch), 32'(mm));
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.a        = 4'd9;
    bus.b        = 4'd9;
    bus.ci       = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 5'd0, 5'd0, 1'b0);
`ifdef FA_SELFCHECK_EN
    check("reset.err_cnt", 32'(bus.err_cnt), 32'd0);
`endif

    @(negedge clk);
    rst = 1'b0;
    apply(1'b1, 4'd3, 4'd5, 1'b0);
    check_all("first", 1'b1, 5'd8, 5'd8, 1'b0);

    apply(1'b1, 4'd15, 4'd1, 1'b0);
    check_all("wrap", 1'b1, 5'd16, 5'd16, 1'b0);
    apply(1'b1, 4'd15, 4'd15, 1'b1);
    check_all("max", 1'b1, 5'd31, 5'd31, 1'b0);

    apply(1'b1, 4'd6, 4'd7, 1'b1);
    check_all("hold_load", 1'b1, 5'd14, 5'd14, 1'b0);
    apply(1'b0, 4'd1, 4'd1, 1'b0);
    check_all("hold", 1'b0, 5'd14, 5'd14, 1'b0);
    apply(1'b0, 4'd1, 4'd1, 1'b0);
    check_all("hold2", 1'b0, 5'd14, 5'd14, 1'b0);

    for (int c = 0; c < 2; c++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          logic [4:0] ref_sum;
          ref_sum = 5'(x) + 5'(y) + 5'(c);
          apply(1'b1, 4'(x), 4'(y), 1'(c));
          check_all($sformatf("exh_%0d_%0d_%0d", c, x, y), 1'b1, ref_sum, ref_sum, 1'b0);
        end
      end
    end

    // Last exhaustive vector (15+15+1) is held in the output registers
    check("pre_async.out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    apply(1'b1, 4'd2, 4'd2, 1'b0);
    check_all("post_rst", 1'b1, 5'd4, 5'd4, 1'b0);

`ifdef FA_SELFCHECK_EN
    check("pre_force.err_cnt", 32'(bus.err_cnt), 32'd0);
    force dut.rip_s = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 4'd0, 4'd0, 1'b0);
      check_all($sformatf("forced_%0d", k), 1'b1, 5'd1, 5'd0, 1'b1);
    end
    release dut.rip_s;
    apply(1'b1, 4'd0, 4'd0, 1'b0);
    check_all("released", 1'b1, 5'd0, 5'd0, 1'b0);
    check("err_cnt", 32'(bus.err_cnt), 32'd3);
    apply(1'b0, 4'd0, 4'd0, 1'b0);
    check("err_cnt_stable", 32'(bus.err_cnt), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
